commutation_sched: RTL and testbench
====================================

COMMUTATION_SCHED -- requirements
Module: commutation_sched

Interface
REQ-001 Parameter STEP_CYC, default 4, clock cycles each commutation step is held (legal range 1..255).
REQ-002 Parameter DWELL_CYC, default 16, minimum cycles the final vector is held before a new request is accepted (legal range 1..65535).
REQ-003 Parameter RESET_VEC, default 6'b000011, switch vector applied out of reset.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  1  new switching vector offered by the optimizer.
REQ-007 req_vec  input  6  requested switching vector.
REQ-008 req_dir  input  1  commutation direction; 0 selects mask 6'b010101, 1 selects mask 6'b101010.
REQ-009 req_ready  output  1  high when a request can be accepted.
REQ-010 vout  output  6  switch gate vector driven to the power stage (registered).
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse when a commutation completes or a no-change request is retired.
REQ-013 step  output  2  current step: 0 none, 1..3 commutation steps.
REQ-014 comm_cnt  output  16  number of completed commutations, saturating at 16'hFFFF.

Function
REQ-015 States SHALL be IDLE, STEP1, STEP2, STEP3, DWELL; req_ready SHALL equal (state==IDLE).
REQ-016 Acceptance SHALL occur on a rising edge where req_valid and req_ready are both high; req_vec and req_dir SHALL be latched as vnew and dir at that edge.
REQ-017 Requests offered while req_ready is low SHALL be ignored, not queued.
REQ-018 If the accepted vnew equals the held vector vold, the block SHALL stay in IDLE, leave vout unchanged, pulse done the next cycle, and not increment comm_cnt.
REQ-019 Otherwise state SHALL go IDLE->STEP1->STEP2->STEP3->DWELL->IDLE, each STEPn held exactly STEP_CYC cycles and DWELL held exactly DWELL_CYC cycles, using one down-counter reloaded on each transition.
REQ-020 With M the dir mask: STEP1 vout = vold & M; STEP2 vout = (vold | vnew) & M; STEP3 vout = vnew & M; DWELL and IDLE vout = vold.
REQ-021 On the STEP3->DWELL transition vold SHALL load vnew, done SHALL pulse for one cycle, and comm_cnt SHALL increment unless already 16'hFFFF.
REQ-022 Latency: with acceptance at edge k, vout SHALL show STEP1 value from edge k+1, the final vector from edge k+1+3*STEP_CYC, and req_ready SHALL rise at edge k+1+3*STEP_CYC+DWELL_CYC.
REQ-023 step SHALL read 1, 2, 3 in STEP1..STEP3 and 0 otherwise; busy SHALL be high in STEP1..DWELL.
REQ-024 req_vec and req_dir changes after acceptance SHALL have no effect on the commutation in progress.
REQ-025 vout SHALL never take a value outside the four REQ-020 forms for the latched vold/vnew/dir.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, vold = vout = RESET_VEC, counter 0, done 0, comm_cnt 0, req_ready 1 after release.
REQ-027 Reset asserted mid-commutation SHALL abort it with no done pulse and no comm_cnt change; vout SHALL return to RESET_VEC asynchronously.

Verification
REQ-028 Defaults, after reset, accept req_vec=001100 dir=0 at edge k -> vout 000001 (k+1..k+4), 000101 (k+5..k+8), 000100 (k+9..k+12), 001100 from k+13, done at k+13, comm_cnt=1, req_ready high at k+29.
REQ-029 From vold=001100, accept 110000 dir=1 -> vout 001000, 101000, 100000 for 4 cycles each, then 110000, done one pulse.
REQ-030 Accept req_vec equal to vold (000011 after reset) -> vout stays 000011, done pulses next cycle, busy stays 0, comm_cnt unchanged.
REQ-031 Hold req_valid high with changing req_vec throughout a commutation and DWELL -> only the first vector is applied; next acceptance exactly at the edge req_ready returns high.
REQ-032 Assert rst_n low during STEP2 -> vout=000011 immediately, no done, comm_cnt unchanged, next request runs normally.
REQ-033 Force comm_cnt to 16'hFFFF via repeated commutations (or STEP_CYC=1, DWELL_CYC=1 build) -> further completions leave it at 16'hFFFF.

Source files
------------

// File: rtl/commutation_sched.sv
// Break-before-make commutation sequencer: walks the gate vector from the held
// vector to a requested one through three masked intermediate steps, then dwells.
module commutation_sched #(
   parameter int unsigned STEP_CYC  = 4,
   parameter int unsigned DWELL_CYC = 16,
   parameter logic [5:0]  RESET_VEC = 6'b000011
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [5:0]  req_vec,
   input  logic        req_dir,
   output logic        req_ready,
   output logic [5:0]  vout,
   output logic        busy,
   output logic        done,
   output logic [1:0]  step,
   output logic [15:0] comm_cnt
);

   // state | meaning
   // IDLE  | holding vold, ready for a request
   // STEP1 | old vector masked by direction
   // STEP2 | union of old and new vectors, masked
   // STEP3 | new vector masked
   // DWELL | new vector fully applied, minimum hold before next request
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_STEP1 = 3'd1;
   localparam logic [2:0] S_STEP2 = 3'd2;
   localparam logic [2:0] S_STEP3 = 3'd3;
   localparam logic [2:0] S_DWELL = 3'd4;

   localparam logic [15:0] STEP_LD  = 16'(STEP_CYC - 1);
   localparam logic [15:0] DWELL_LD = 16'(DWELL_CYC - 1);

   logic [2:0]  state;
   logic [15:0] cnt;
   logic [5:0]  vold;
   logic [5:0]  vnew;
   logic        dir;

   function automatic logic [5:0] dir_mask(input logic d);
      return d ? 6'b101010 : 6'b010101;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         vold     <= RESET_VEC;
         vnew     <= RESET_VEC;
         dir      <= 1'b0;
         vout     <= RESET_VEC;
         done     <= 1'b0;
         comm_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  vnew <= req_vec;
                  dir  <= req_dir;
                  // a no-change request is retired in place
                  if (req_vec == vold) begin
                     done <= 1'b1;
                  end else begin
                     state <= S_STEP1;
                     cnt   <= STEP_LD;
                     vout  <= vold & dir_mask(req_dir);
                  end
               end
            end
            S_STEP1: begin
               if (cnt == '0) begin
                  state <= S_STEP2;
                  cnt   <= STEP_LD;
                  vout  <= (vold | vnew) & dir_mask(dir);
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_STEP2: begin
               if (cnt == '0) begin
                  state <= S_STEP3;
                  cnt   <= STEP_LD;
                  vout  <= vnew & dir_mask(dir);
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_STEP3: begin
               if (cnt == '0) begin
                  state <= S_DWELL;
                  cnt   <= DWELL_LD;
                  vout  <= vnew;
                  vold  <= vnew;
                  done  <= 1'b1;
                  if (comm_cnt != 16'hFFFF) comm_cnt <= comm_cnt + 16'd1;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_DWELL: begin
               if (cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               vout  <= vold;
            end
         endcase
      end
   end

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   always_comb begin
      step = 2'd0;
      case (state)
         S_STEP1: step = 2'd1;
         S_STEP2: step = 2'd2;
         S_STEP3: step = 2'd3;
         default: step = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_commutation_sched.sv
// Directed bench for commutation_sched: the stimulus queues expected completions,
// a monitor retires them on every done pulse.
module tb_commutation_sched;

   localparam int STEP  = 4;
   localparam int DWELL = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [5:0]  req_vec = '0;
   logic        req_dir = 1'b0;
   logic        req_ready;
   logic [5:0]  vout;
   logic        busy;
   logic        done;
   logic [1:0]  step;
   logic [15:0] comm_cnt;

   typedef struct {
      logic [5:0]  vec;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   commutation_sched #(.STEP_CYC(STEP), .DWELL_CYC(DWELL), .RESET_VEC(6'b000011)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vec(req_vec),
      .req_dir(req_dir), .req_ready(req_ready), .vout(vout), .busy(busy),
      .done(done), .step(step), .comm_cnt(comm_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every done pulse retires one queued expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 16'd1, 16'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("done_vout", {10'd0, vout}, {10'd0, e.vec});
            chk("done_cnt", comm_cnt, e.cnt);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // called just after the accepting edge; ends just after the edge where ready returns
   task automatic run_comm(input logic [5:0] vo, input logic [5:0] vn, input logic d,
                           input bit junk, input logic [5:0] nv, input logic nd);
      logic [5:0] m;
      logic [5:0] e;
      logic [1:0] s;
      m = d ? 6'b101010 : 6'b010101;
      for (int j = 0; j < 3*STEP + DWELL; j++) begin
         if (j < STEP)        begin e = vo & m;        s = 2'd1; end
         else if (j < 2*STEP) begin e = (vo | vn) & m; s = 2'd2; end
         else if (j < 3*STEP) begin e = vn & m;        s = 2'd3; end
         else                 begin e = vn;            s = 2'd0; end
         chk("vout_seq", {10'd0, vout}, {10'd0, e});
         chk("step_seq", {14'd0, step}, {14'd0, s});
         chk("ready_low", {15'd0, req_ready}, 16'd0);
         chk("done_timing", {15'd0, done}, (j == 3*STEP) ? 16'd1 : 16'd0);
         if (junk) begin
            if (j == 3*STEP + DWELL - 1) begin
               req_vec = nv;
               req_dir = nd;
            end else begin
               req_vec = 6'($urandom_range(63));
               req_dir = 1'($urandom_range(1));
            end
         end
         if (j < 3*STEP + DWELL - 1) tick();
      end
      tick();
      chk("ready_back", {15'd0, req_ready}, 16'd1);
      chk("busy_back", {15'd0, busy}, 16'd0);
      chk("vout_final", {10'd0, vout}, {10'd0, vn});
   endtask

   task automatic accept(input logic [5:0] v, input logic d, input logic [5:0] ev,
                         input logic [15:0] ec);
      exp_t e;
      e.vec = ev;
      e.cnt = ec;
      exp_q.push_back(e);
      req_valid = 1'b1;
      req_vec   = v;
      req_dir   = d;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #12;
      chk("rst_vout", {10'd0, vout}, 16'h0003);
      chk("rst_done", {15'd0, done}, 16'd0);
      chk("rst_cnt", comm_cnt, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_step", {14'd0, step}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_ready", {15'd0, req_ready}, 16'd1);

      // no-change request retires in place
      accept(6'b000011, 1'b0, 6'b000011, 16'd0);
      chk("nc_busy", {15'd0, busy}, 16'd0);
      chk("nc_vout", {10'd0, vout}, 16'h0003);
      chk("nc_done", {15'd0, done}, 16'd1);
      tick();
      chk("nc_done_clr", {15'd0, done}, 16'd0);
      chk("nc_cnt", comm_cnt, 16'd0);

      // default walk 000011 -> 001100, dir 0
      accept(6'b001100, 1'b0, 6'b001100, 16'd1);
      run_comm(6'b000011, 6'b001100, 1'b0, 1'b0, 6'd0, 1'b0);

      // 001100 -> 110000 dir 1 with req_valid held and junk vectors offered
      exp_q.push_back('{vec: 6'b110000, cnt: 16'd2});
      req_valid = 1'b1;
      req_vec   = 6'b110000;
      req_dir   = 1'b1;
      tick();
      run_comm(6'b001100, 6'b110000, 1'b1, 1'b1, 6'b001100, 1'b0);
      exp_q.push_back('{vec: 6'b001100, cnt: 16'd3});
      tick();
      req_valid = 1'b0;
      chk("rearm_busy", {15'd0, busy}, 16'd1);
      run_comm(6'b110000, 6'b001100, 1'b0, 1'b0, 6'd0, 1'b0);

      // reset during STEP2 aborts without a done pulse
      req_valid = 1'b1;
      req_vec   = 6'b110000;
      req_dir   = 1'b0;
      tick();
      req_valid = 1'b0;
      repeat (STEP) tick();
      chk("abort_step", {14'd0, step}, 16'd2);
      chk("abort_vout_pre", {10'd0, vout}, 16'h0014);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_vout", {10'd0, vout}, 16'h0003);
      chk("abort_busy", {15'd0, busy}, 16'd0);
      chk("abort_done", {15'd0, done}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("abort_cnt", comm_cnt, 16'd0);
      accept(6'b001100, 1'b0, 6'b001100, 16'd1);
      run_comm(6'b000011, 6'b001100, 1'b0, 1'b0, 6'd0, 1'b0);

      // saturation of the completion counter
      @(negedge clk);
      force dut.comm_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.comm_cnt;
      #6;
      accept(6'b000011, 1'b1, 6'b000011, 16'hFFFF);
      run_comm(6'b001100, 6'b000011, 1'b1, 1'b0, 6'd0, 1'b0);
      accept(6'b001100, 1'b0, 6'b001100, 16'hFFFF);
      run_comm(6'b000011, 6'b001100, 1'b0, 1'b0, 6'd0, 1'b0);

      repeat (4) tick();
      chk("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
